rns_conv_seq: RTL

Multi-cycle sequencer for the four-modulus (255/256/257/511) residue conversion datapath. Accepts one residue set per valid/ready handshake, steps a single shared multiply/mod-reduce path through the Q0 → Q2 → T → S sequence with a state machine, and presents the registered results S1..S4 with a valid/ready output handshake. It sits between the residue source and any consumer of converted digits, replacing the purely combinational evaluation with a timed, back-pressurable unit.

---
 rtl/rns_conv_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rns_conv_seq.sv
// Multi-cycle residue conversion sequencer: four-modulus (255/256/257/511) set in, digits S1..S4 out.
// Latency: 4 cycles from capture edge to out_valid for a legal set, 1 cycle for an out-of-range set.
// Backpressure: accepts only in IDLE; holds results in DONE until out_ready, no bypass or queueing.
module rns_conv_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       r1,
  input  logic [7:0]       r2,
  input  logic [8:0]       r3,
  input  logic [8:0]       r4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       s1,
  output logic [7:0]       s2,
  output logic [8:0]       s3,
  output logic [8:0]       s4,
  output logic             range_err,
  output logic [CNT_W-1:0] conv_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_Q0  = 3'd1,
    S_Q2  = 3'd2,
    S_T   = 3'd3,
    S_OUT = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nx;

  // Captured residue set; only these feed the datapath, so live inputs may change freely.
  logic [7:0] a1, a2;
  logic [8:0] a3, a4;

  // Registered intermediates passed between sequence steps.
  logic [7:0] q0;
  logic [8:0] q2m;
  logic [8:0] t;

  // Combinational step results; each one is consumed by exactly one state's register load.
  logic        in_bad;
  logic [25:0] q0_sum;
  logic [7:0]  q0_nx;
  logic [7:0]  s1_nx;
  logic [8:0]  s3_nx;
  logic [8:0]  q2m_nx;
  logic [9:0]  t_diff;
  logic [18:0] t_prod;
  logic [8:0]  t_nx;
  logic [7:0]  s2_nx;
  logic [8:0]  s4_nx;

  // Step arithmetic. The +65535 term keeps the Q0 sum non-negative before the mod-65535 fold;
  // the worst-case sum exceeds 2^24, hence the 26-bit accumulator.
  always_comb begin
    in_bad = (r1 > 8'd254) || (r3 > 9'd256) || (r4 > 9'd510);
    q0_sum = 26'(a1) * 26'd32896 + 26'd65535 - (26'(a2) << 8) + 26'(a3) * 26'd32895;
    q0_nx  = 8'(q0_sum % 26'd65535);
    s1_nx  = 8'((10'(a1) + 10'd255 - 10'(a2)) % 10'd255);
    s3_nx  = 9'((10'(a2) + 10'd257 - 10'(a3)) % 10'd257);
    q2m_nx = 9'({q0, a2} % 16'd511);
    t_diff = 10'(a4) + 10'd511 - 10'(q2m);
    t_prod = 19'(t_diff) * 19'd338;
    t_nx   = 9'(t_prod % 19'd511);
    s2_nx  = q0 - t[7:0];
    s4_nx  = 9'((16'(q0) + 16'(t) * 16'd127) % 16'd511);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs. A bad set still spends one cycle in S_Q0 before DONE,
  // which sets its 1-cycle result latency and 3-cycle issue interval.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_Q0;
      end
      S_Q0:  state_nx = range_err ? DONE : S_Q2;
      S_Q2:  state_nx = S_T;
      S_T:   state_nx = S_OUT;
      S_OUT: state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath registers: capture in IDLE, one reduction step per state, count accepted results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1        <= '0;
      a2        <= '0;
      a3        <= '0;
      a4        <= '0;
      q0        <= '0;
      q2m       <= '0;
      t         <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      range_err <= 1'b0;
      conv_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a1        <= r1;
            a2        <= r2;
            a3        <= r3;
            a4        <= r4;
            range_err <= in_bad;
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            s4        <= '0;
          end
        end
        S_Q0: begin
          if (!range_err) begin
            q0 <= q0_nx;
            s1 <= s1_nx;
            s3 <= s3_nx;
          end
        end
        S_Q2:  q2m <= q2m_nx;
        S_T:   t   <= t_nx;
        S_OUT: begin
          s2 <= s2_nx;
          s4 <= s4_nx;
        end
        DONE: begin
          if (out_ready) conv_cnt <= conv_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
